// File: rtl/palette_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : palette_pkg
//  Description : Shared types, widths and helpers for the palette write path.
//                Holds the sequencer state encoding, the palette memory port
//                widths, the colour type and the colour-to-word split helpers.
//  Revision    : 1.0  initial release
// ============================================================================
package palette_pkg;

    localparam int PAL_ADDR_W  = 8;
    localparam int PAL_DATA_W  = 16;
    localparam int PAL_COLOR_W = 24;

    typedef logic [PAL_COLOR_W-1:0] pal_color_t;

    // Encoding reflects the write currently presented on the memory port.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_LO   = 3'd1,
        ST_WR_HI   = 3'd2,
        ST_FILL_LO = 3'd3,
        ST_FILL_HI = 3'd4
    } pal_wr_state_t;

    // Low word: green and blue bytes, written at the even address.
    function automatic logic [PAL_DATA_W-1:0] pal_lo_word(input pal_color_t c);
        return c[15:0];
    endfunction

    // High word: red byte zero-extended, written at the odd address.
    function automatic logic [PAL_DATA_W-1:0] pal_hi_word(input pal_color_t c);
        return {8'h00, c[23:16]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter2.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter2
//  Description : Two-way round-robin grant. A single pointer bit names the
//                requester that wins a tie; on every advance the pointer moves
//                to the requester that was not granted.
//  Ports       : clk, reset (sync, active-high)
//                i_req[1:0]   request vector (0 = CPU, 1 = DMA)
//                i_advance    a grant was consumed this cycle
//                o_gnt[1:0]   one-hot (or zero) combinational grant
//  Revision    : 1.0  initial release
// ============================================================================
module rr_arbiter2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] i_req,
    input  logic       i_advance,
    output logic [1:0] o_gnt
);

    // 0: requester 0 wins a tie, 1: requester 1 wins a tie.
    logic r_ptr;

    assign o_gnt[0] = i_req[0] & (~i_req[1] | ~r_ptr);
    assign o_gnt[1] = i_req[1] & (~i_req[0] |  r_ptr);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr <= 1'b0;
        end else if (i_advance) begin
            r_ptr <= o_gnt[0];
        end
    end

endmodule
`default_nettype wire

// File: rtl/palette_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : palette_write_arbiter
//  Description : Sequences every write into the palette memory. CPU and DMA
//                requests share the single write port through a round-robin
//                arbiter; a fill engine can overwrite all entries. Each 24-bit
//                colour becomes two back-to-back 16-bit writes: low word at
//                {index,0}, high byte at {index,1}.
//  Config      : PAL_WRITE_WINDOW_EN - adds pal_write_window; acceptance of
//                requests and fill_start is allowed only while it is high,
//                and a running fill pauses between entries while it is low.
//  Ports       : clk, reset (sync, active-high)
//                cpu_valid/cpu_ready/cpu_index/cpu_color  CPU request channel
//                dma_valid/dma_ready/dma_index/dma_color  DMA request channel
//                fill_start/fill_color/fill_done          fill engine control
//                busy                                     sequencer not idle
//                pal_write_addr/data/enable               memory write port
//                pal_write_window                         (optional) gate
//  Revision    : 1.0  initial release
// ============================================================================
module palette_write_arbiter
    import palette_pkg::*;
#(
    parameter int INDEX_W = 7,
    parameter int COLOR_W = 24
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cpu_valid,
    output logic                   cpu_ready,
    input  logic [INDEX_W-1:0]     cpu_index,
    input  logic [COLOR_W-1:0]     cpu_color,
    input  logic                   dma_valid,
    output logic                   dma_ready,
    input  logic [INDEX_W-1:0]     dma_index,
    input  logic [COLOR_W-1:0]     dma_color,
    input  logic                   fill_start,
    input  logic [COLOR_W-1:0]     fill_color,
    output logic                   fill_done,
    output logic                   busy,
`ifdef PAL_WRITE_WINDOW_EN
    input  logic                   pal_write_window,
`endif
    output logic [PAL_ADDR_W-1:0]  pal_write_addr,
    output logic [PAL_DATA_W-1:0]  pal_write_data,
    output logic                   pal_write_enable
);

    localparam logic [INDEX_W-1:0] c_LAST_IDX = '1;

    pal_wr_state_t          r_state;
    logic [INDEX_W-1:0]     r_idx;
    logic [INDEX_W-1:0]     r_cnt;
    pal_color_t             r_color;
    logic                   r_fill_done;
    logic                   r_wr_en;
    logic [PAL_ADDR_W-1:0]  r_wr_addr;
    logic [PAL_DATA_W-1:0]  r_wr_data;

    logic                   w_window;
    logic                   w_idle;
    logic                   w_accept_fill;
    logic                   w_arb_en;
    logic [1:0]             w_req;
    logic [1:0]             w_gnt;
    logic [INDEX_W-1:0]     w_cnt_next;

`ifdef PAL_WRITE_WINDOW_EN
    assign w_window = pal_write_window;
`else
    assign w_window = 1'b1;
`endif

    function automatic logic [PAL_ADDR_W-1:0] mk_addr(input logic [INDEX_W-1:0] idx,
                                                      input logic             hi);
        return PAL_ADDR_W'({idx, hi});
    endfunction

    // Reset is folded in so both readies read 0 while reset is asserted.
    assign w_idle        = (r_state == ST_IDLE) && !reset;
    assign w_accept_fill = w_idle && w_window && fill_start;
    // A fill request shadows both requesters for the cycle it is accepted.
    assign w_arb_en      = w_idle && w_window && !fill_start;
    assign w_req         = {dma_valid & w_arb_en, cpu_valid & w_arb_en};
    assign w_cnt_next    = r_cnt + 1'b1;

    // Requests are pre-masked, so any grant is a real transfer.
    rr_arbiter2 u_rr (
        .clk       (clk),
        .reset     (reset),
        .i_req     (w_req),
        .i_advance (|w_gnt),
        .o_gnt     (w_gnt)
    );

    assign cpu_ready        = w_gnt[0];
    assign dma_ready        = w_gnt[1];
    assign busy             = (r_state != ST_IDLE);
    assign fill_done        = r_fill_done;
    assign pal_write_enable = r_wr_en;
    assign pal_write_addr   = r_wr_addr;
    assign pal_write_data   = r_wr_data;

    // Outputs for the next state are computed on the transition edge so that
    // the write port always shows the write belonging to the current state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_idx       <= '0;
            r_cnt       <= '0;
            r_color     <= '0;
            r_fill_done <= 1'b0;
            r_wr_en     <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
        end else begin
            r_fill_done <= 1'b0;
            r_wr_en     <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept_fill) begin
                        r_state   <= ST_FILL_LO;
                        r_cnt     <= '0;
                        r_color   <= fill_color;
                        r_wr_en   <= 1'b1;
                        r_wr_addr <= mk_addr('0, 1'b0);
                        r_wr_data <= pal_lo_word(fill_color);
                    end else if (w_gnt[0]) begin
                        r_state   <= ST_WR_LO;
                        r_idx     <= cpu_index;
                        r_color   <= cpu_color;
                        r_wr_en   <= 1'b1;
                        r_wr_addr <= mk_addr(cpu_index, 1'b0);
                        r_wr_data <= pal_lo_word(cpu_color);
                    end else if (w_gnt[1]) begin
                        r_state   <= ST_WR_LO;
                        r_idx     <= dma_index;
                        r_color   <= dma_color;
                        r_wr_en   <= 1'b1;
                        r_wr_addr <= mk_addr(dma_index, 1'b0);
                        r_wr_data <= pal_lo_word(dma_color);
                    end
                end
                // The high half always follows, whatever the window does.
                ST_WR_LO: begin
                    r_state   <= ST_WR_HI;
                    r_wr_en   <= 1'b1;
                    r_wr_addr <= mk_addr(r_idx, 1'b1);
                    r_wr_data <= pal_hi_word(r_color);
                end
                ST_WR_HI: begin
                    r_state <= ST_IDLE;
                end
                ST_FILL_LO: begin
                    r_state   <= ST_FILL_HI;
                    r_wr_en   <= 1'b1;
                    r_wr_addr <= mk_addr(r_cnt, 1'b1);
                    r_wr_data <= pal_hi_word(r_color);
                end
                // Last entry ends the fill without wrapping the counter.
                // Otherwise a closed window parks here with the port idle.
                ST_FILL_HI: begin
                    if (r_cnt == c_LAST_IDX) begin
                        r_state     <= ST_IDLE;
                        r_fill_done <= 1'b1;
                    end else if (w_window) begin
                        r_state   <= ST_FILL_LO;
                        r_cnt     <= w_cnt_next;
                        r_wr_en   <= 1'b1;
                        r_wr_addr <= mk_addr(w_cnt_next, 1'b0);
                        r_wr_data <= pal_lo_word(r_color);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_palette_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_palette_write_arbiter
//  Description : Directed self-checking bench for palette_write_arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_palette_write_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_valid, dma_valid, fill_start;
    logic        cpu_ready, dma_ready, fill_done, busy;
    logic [6:0]  cpu_index, dma_index;
    logic [23:0] cpu_color, dma_color, fill_color;
    logic [7:0]  pal_write_addr;
    logic [15:0] pal_write_data;
    logic        pal_write_enable;
`ifdef PAL_WRITE_WINDOW_EN
    logic        pal_write_window;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    palette_write_arbiter #(.INDEX_W(7), .COLOR_W(24)) dut (
        .clk              (clk),
        .reset            (reset),
        .cpu_valid        (cpu_valid),
        .cpu_ready        (cpu_ready),
        .cpu_index        (cpu_index),
        .cpu_color        (cpu_color),
        .dma_valid        (dma_valid),
        .dma_ready        (dma_ready),
        .dma_index        (dma_index),
        .dma_color        (dma_color),
        .fill_start       (fill_start),
        .fill_color       (fill_color),
        .fill_done        (fill_done),
        .busy             (busy),
`ifdef PAL_WRITE_WINDOW_EN
        .pal_write_window (pal_write_window),
`endif
        .pal_write_addr   (pal_write_addr),
        .pal_write_data   (pal_write_data),
        .pal_write_enable (pal_write_enable)
    );

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Write port as one word: {enable, addr, data}.
    function automatic logic [31:0] port_word;
        return {7'd0, pal_write_enable, pal_write_addr, pal_write_data};
    endfunction

    // Entered on the first FILL_LO cycle; leaves on the first IDLE cycle.
    task automatic run_fill(input logic [23:0] c);
        logic [15:0] d;
        for (int a = 0; a < 256; a++) begin
            d = a[0] ? {8'h00, c[23:16]} : c[15:0];
            chk_eq("fill_wr", port_word(), {7'd0, 1'b1, a[7:0], d});
            chk_eq("fill_done_early", {31'd0, fill_done}, 32'd0);
            step();
        end
        chk_eq("fill_done", {31'd0, fill_done}, 32'd1);
        chk_eq("fill_end_en", {31'd0, pal_write_enable}, 32'd0);
        chk_eq("fill_end_busy", {31'd0, busy}, 32'd0);
    endtask

    task automatic do_reset;
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        step();
    endtask

    initial begin
        logic [6:0]  exp_idx;
        logic [23:0] exp_col;
        int          stray;

        reset = 1'b1; cpu_valid = 0; dma_valid = 0; fill_start = 0;
        cpu_index = '0; dma_index = '0; cpu_color = '0; dma_color = '0; fill_color = '0;
`ifdef PAL_WRITE_WINDOW_EN
        pal_write_window = 1'b1;
`endif
        step();
        step();
        chk_eq("rst_port", port_word(), 32'd0);
        chk_eq("rst_busy", {31'd0, busy}, 32'd0);
        chk_eq("rst_done", {31'd0, fill_done}, 32'd0);
        reset = 1'b0;
        step();

        // Single CPU write.
        cpu_valid = 1; cpu_index = 7'h05; cpu_color = 24'hA1B2C3;
        #1;
        chk_eq("cpu1_ready", {30'd0, dma_ready, cpu_ready}, 32'd1);
        step();
        cpu_valid = 0;
        chk_eq("cpu1_lo", port_word(), {7'd0, 1'b1, 8'h0A, 16'hB2C3});
        chk_eq("cpu1_busy", {31'd0, busy}, 32'd1);
        step();
        chk_eq("cpu1_hi", port_word(), {7'd0, 1'b1, 8'h0B, 16'h00A1});
        step();
        chk_eq("cpu1_idle", port_word(), {7'd0, 1'b0, 8'h0B, 16'h00A1});
        chk_eq("cpu1_busy_end", {31'd0, busy}, 32'd0);

        // Both requesters held: grants alternate CPU, DMA, CPU, DMA.
        do_reset();
        cpu_valid = 1; dma_valid = 1;
        for (int k = 0; k < 4; k++) begin
            cpu_index = 7'h10 + 7'(k); cpu_color = {8'hC0 + 8'(k), 16'h1200 + 16'(k)};
            dma_index = 7'h20 + 7'(k); dma_color = {8'hD0 + 8'(k), 16'h3400 + 16'(k)};
            exp_idx = k[0] ? dma_index : cpu_index;
            exp_col = k[0] ? dma_color : cpu_color;
            #1;
            chk_eq("rr_grant", {30'd0, dma_ready, cpu_ready}, k[0] ? 32'd2 : 32'd1);
            step();
            chk_eq("rr_lo", port_word(), {7'd0, 1'b1, exp_idx, 1'b0, exp_col[15:0]});
            chk_eq("rr_rdy_busy", {30'd0, dma_ready, cpu_ready}, 32'd0);
            step();
            chk_eq("rr_hi", port_word(), {7'd0, 1'b1, exp_idx, 1'b1, 8'h00, exp_col[23:16]});
            step();
        end
        cpu_valid = 0; dma_valid = 0;

        // Fill beats a pending CPU request, then the CPU is served.
        cpu_valid = 1; cpu_index = 7'h03; cpu_color = 24'hABCDEF;
        fill_start = 1; fill_color = 24'h102030;
        #1;
        chk_eq("fill_beats_cpu", {30'd0, dma_ready, cpu_ready}, 32'd0);
        step();
        fill_start = 0;
        run_fill(24'h102030);
        chk_eq("post_fill_cpu_rdy", {31'd0, cpu_ready}, 32'd1);
        step();
        cpu_valid = 0;
        chk_eq("post_fill_cpu_lo", port_word(), {7'd0, 1'b1, 8'h06, 16'hCDEF});
        chk_eq("post_fill_done_clr", {31'd0, fill_done}, 32'd0);
        step();
        step();

        // Reset during WR_LO: no WR_HI follows.
        cpu_valid = 1; cpu_index = 7'h09; cpu_color = 24'h778899;
        step();
        cpu_valid = 0;
        chk_eq("rstlo_lo", port_word(), {7'd0, 1'b1, 8'h12, 16'h8899});
        reset = 1;
        step();
        chk_eq("rstlo_en", {31'd0, pal_write_enable}, 32'd0);
        chk_eq("rstlo_busy", {31'd0, busy}, 32'd0);
        reset = 0;
        step();
        chk_eq("rstlo_no_hi", {31'd0, pal_write_enable}, 32'd0);

        // Reset mid-fill at index 40, then a fresh fill starts at index 0.
        fill_start = 1; fill_color = 24'h0A0B0C;
        step();
        fill_start = 0;
        for (int a = 0; a < 80; a++) step();
        chk_eq("midfill_at40", port_word(), {7'd0, 1'b1, 8'd80, 16'h0B0C});
        reset = 1;
        step();
        chk_eq("midfill_rst_en", {30'd0, busy, pal_write_enable}, 32'd0);
        reset = 0;
        stray = 0;
        for (int a = 0; a < 6; a++) begin
            step();
            if (pal_write_enable || fill_done || busy) stray++;
        end
        chk_eq("midfill_quiet", stray, 32'd0);
        fill_start = 1; fill_color = 24'h445566;
        step();
        fill_start = 0;
        run_fill(24'h445566);
        step();
        chk_eq("refill_done_pulse", {31'd0, fill_done}, 32'd0);

`ifdef PAL_WRITE_WINDOW_EN
        // Window gating: closed window blocks acceptance, open pair completes.
        pal_write_window = 0;
        cpu_valid = 1; cpu_index = 7'h11; cpu_color = 24'h123456;
        #1;
        chk_eq("win_closed_rdy", {31'd0, cpu_ready}, 32'd0);
        step();
        chk_eq("win_closed_en", {31'd0, pal_write_enable}, 32'd0);
        pal_write_window = 1;
        #1;
        chk_eq("win_open_rdy", {31'd0, cpu_ready}, 32'd1);
        step();
        cpu_valid = 0;
        pal_write_window = 0;
        chk_eq("win_lo", port_word(), {7'd0, 1'b1, 8'h22, 16'h3456});
        step();
        chk_eq("win_hi", port_word(), {7'd0, 1'b1, 8'h23, 16'h0012});
        pal_write_window = 1;
        step();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
